// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate self-test sequencer.
// Holds the FSM state encoding, the standard 2-input truth tables and the
// helper that sizes the settle timer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Expected y indexed by {a,b}: bit0 is y for 00, bit3 is y for 11.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  // The timer only ever holds HOLD_CYCLES-1, so clog2(HOLD_CYCLES) bits
  // suffice. The floor of 1 keeps HOLD_CYCLES=1 from giving a zero-width bus.
  function automatic int timer_width(input int hold);
    return ($clog2(hold) < 1) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Loadable down-counter used to time the settle window of each vector.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (count clears to 0)
//   load        load load_val (takes priority over en)
//   en          decrement by one
//   load_val    reload value
//   zero        count is zero
module gate_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// On-chip self-test driver for a 2-input gate. Walks {a,b} through
// 00, 01, 10, 11, holds each vector for HOLD_CYCLES settle cycles plus one
// check cycle, compares y_dut against TRUTH and accumulates errors.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   start       begin a run (honoured in IDLE or DONE only)
//   abort       synchronous return to IDLE, keeps err_cnt/fail_vec
//   y_dut       output of the gate under test
//   a, b        gate inputs, straight from the vector register
//   busy        high in SETTLE and CHECK
//   done, pass  run finished / finished with no mismatches
//   err_cnt     mismatch count 0..4
//   fail_vec    bit i set if vector i mismatched
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int         HOLD_CYCLES  = 10,
  parameter logic [3:0] TRUTH        = TT_NAND,
  parameter bit         STOP_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_dut,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam int TW = timer_width(HOLD_CYCLES);

  state_t     state, state_n;
  logic [1:0] vec, vec_n;
  logic [2:0] err_n;
  logic [3:0] fail_n;
  logic       t_load, t_en, t_zero, mismatch;

  gate_seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .en       (t_en),
    .load_val (TW'(HOLD_CYCLES - 1)),
    .zero     (t_zero)
  );

  assign mismatch = (y_dut != TRUTH[vec]);

  always_comb begin
    state_n = state;
    vec_n   = vec;
    err_n   = err_cnt;
    fail_n  = fail_vec;
    t_load  = 1'b0;
    t_en    = 1'b0;
    if (abort && state != IDLE) begin
      // Abort wins over start and over a pending CHECK result.
      state_n = IDLE;
      vec_n   = 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n = SETTLE;
            vec_n   = 2'd0;
            err_n   = 3'd0;
            fail_n  = 4'd0;
            t_load  = 1'b1;
          end
        end
        SETTLE: begin
          if (t_zero) state_n = CHECK;
          else        t_en    = 1'b1;
        end
        CHECK: begin
          if (mismatch) begin
            err_n      = err_cnt + 3'd1;
            fail_n[vec] = 1'b1;
          end
          if (vec == 2'd3 || (mismatch && STOP_ON_FAIL)) begin
            state_n = DONE;
          end else begin
            state_n = SETTLE;
            vec_n   = vec + 2'd1;
            t_load  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= 2'd0;
      err_cnt  <= 3'd0;
      fail_vec <= 4'd0;
    end else begin
      state    <= state_n;
      vec      <= vec_n;
      err_cnt  <= err_n;
      fail_vec <= fail_n;
    end
  end

  assign a    = vec[1];
  assign b    = vec[0];
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 3'd0);

endmodule

// File: tb/tb_gate_test_sequencer.sv
module tb_gate_test_sequencer;
  import gate_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, start_s = 1'b0;
  logic a, b, busy, done, pass;
  logic a_s, b_s, busy_s, done_s, pass_s;
  logic [2:0] err_cnt, err_s;
  logic [3:0] fail_vec, fail_s;
  logic y, y_s;
  int   mode = 0;  // 0: NAND gate, 1: AND gate, 2: stuck-at-0
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      0:       begin y = ~(a & b); y_s = ~(a_s & b_s); end
      1:       begin y = a & b;    y_s = a_s & b_s;    end
      default: begin y = 1'b0;     y_s = 1'b0;         end
    endcase
  end

  gate_test_sequencer #(.HOLD_CYCLES(10), .TRUTH(TT_NAND), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .y_dut(y),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_vec(fail_vec)
  );

  gate_test_sequencer #(.HOLD_CYCLES(10), .TRUTH(TT_NAND), .STOP_ON_FAIL(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .abort(1'b0), .y_dut(y_s),
    .a(a_s), .b(b_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_cnt(err_s), .fail_vec(fail_s)
  );

  // Pulses start across one posedge (edge 0 of the run).
  task automatic start_run(input bit sel);
    @(negedge clk);
    if (sel) start_s = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_s = 1'b0;
  endtask

  // Cycles from the start edge until done is seen; -1 on timeout.
  task automatic wait_done(input bit sel, output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (sel ? done_s : done) return;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({a, b, busy, done, pass, err_cnt, fail_vec} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset: outputs=%b required all zero", {a, b, busy, done, pass, err_cnt, fail_vec});
    end
  endtask

  task automatic test_nand_pass();
    int k, ev, bad;
    mode = 0;
    start_run(0);
    bad = 0;
    for (k = 1; k <= 44; k++) begin
      @(posedge clk); #1;
      ev = (k / 11 > 3) ? 3 : k / 11;
      if ({a, b} !== 2'(ev) || (k < 44 && busy !== 1'b1) || (k < 44 && done !== 1'b0)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL nand_steps: %0d cycles with wrong {a,b}/busy/done, required 0", bad);
    end
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nand_done_at_44: done=%b pass=%b busy=%b required 1 1 0", done, pass, busy);
    end
    n_checks++;
    if (err_cnt !== 3'd0 || fail_vec !== 4'b0000 || {a, b} !== 2'b11) begin
      n_fail++;
      $display("FAIL nand_result: err=%0d fail=%b ab=%b required 0 0000 11", err_cnt, fail_vec, {a, b});
    end
  endtask

  task automatic test_and_dut();
    int cyc;
    mode = 1;
    start_run(0);
    wait_done(0, cyc);
    n_checks++;
    if (cyc !== 44) begin
      n_fail++;
      $display("FAIL and_latency: got %0d cycles required 44", cyc);
    end
    n_checks++;
    if (err_cnt !== 3'd4 || fail_vec !== 4'b1111 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL and_result: err=%0d fail=%b pass=%b required 4 1111 0", err_cnt, fail_vec, pass);
    end
  endtask

  task automatic test_stuck0();
    int cyc;
    mode = 2;
    start_run(0);
    wait_done(0, cyc);
    n_checks++;
    if (cyc !== 44 || err_cnt !== 3'd3 || fail_vec !== 4'b0111 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck0_run: cyc=%0d err=%0d fail=%b pass=%b required 44 3 0111 0", cyc, err_cnt, fail_vec, pass);
    end
    start_run(1);
    wait_done(1, cyc);
    n_checks++;
    if (cyc !== 11) begin
      n_fail++;
      $display("FAIL stop_on_fail_latency: got %0d cycles required 11", cyc);
    end
    n_checks++;
    if (err_s !== 3'd1 || fail_s !== 4'b0001 || {a_s, b_s} !== 2'b00 || pass_s !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_on_fail_result: err=%0d fail=%b ab=%b pass=%b required 1 0001 00 0", err_s, fail_s, {a_s, b_s}, pass_s);
    end
  endtask

  task automatic test_start_ignored_abort();
    int cyc;
    mode = 2;
    start_run(0);
    repeat (15) begin @(posedge clk); #1; end
    start_run(0);  // edge 16, vector 1 settling
    n_checks++;
    if ({a, b} !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_ignored: ab=%b busy=%b required 01 1", {a, b}, busy);
    end
    repeat (16) begin @(posedge clk); #1; end  // after edge 32: CHECK of vector 2
    n_checks++;
    if ({a, b} !== 2'b10 || busy !== 1'b1 || err_cnt !== 3'd2) begin
      n_fail++;
      $display("FAIL timing_after_ignored_start: ab=%b busy=%b err=%0d required 10 1 2", {a, b}, busy, err_cnt);
    end
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    n_checks++;
    if ({a, b} !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: ab=%b busy=%b done=%b pass=%b required 00 0 0 0", {a, b}, busy, done, pass);
    end
    n_checks++;
    if (err_cnt !== 3'd2 || fail_vec !== 4'b0011) begin
      n_fail++;
      $display("FAIL abort_retain: err=%0d fail=%b required 2 0011", err_cnt, fail_vec);
    end
    mode = 0;
    start_run(0);
    n_checks++;
    if (err_cnt !== 3'd0 || fail_vec !== 4'b0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clears: err=%0d fail=%b busy=%b required 0 0000 1", err_cnt, fail_vec, busy);
    end
    wait_done(0, cyc);
    n_checks++;
    if (cyc !== 44 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL after_abort_run: cyc=%0d pass=%b required 44 1", cyc, pass);
    end
  endtask

  task automatic test_async_reset();
    mode = 2;
    start_run(0);
    repeat (25) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a, b, busy, err_cnt, fail_vec} !== 10'd0) begin
      n_fail++;
      $display("FAIL async_reset: a,b,busy,err,fail=%b required all zero", {a, b, busy, err_cnt, fail_vec});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {a, b} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b ab=%b required 0 0 00", busy, done, {a, b});
    end
  endtask

  task automatic test_restart_from_done();
    int cyc;
    mode = 1;
    start_run(0);
    wait_done(0, cyc);
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_restart: done=%b pass=%b required 1 0", done, pass);
    end
    mode = 0;
    start_run(0);
    n_checks++;
    if (done !== 1'b0 || err_cnt !== 3'd0 || busy !== 1'b1 || {a, b} !== 2'b00) begin
      n_fail++;
      $display("FAIL restart_edge: done=%b err=%0d busy=%b ab=%b required 0 0 1 00", done, err_cnt, busy, {a, b});
    end
    wait_done(0, cyc);
    n_checks++;
    if (cyc !== 44 || pass !== 1'b1 || fail_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL restart_run: cyc=%0d pass=%b fail=%b required 44 1 0000", cyc, pass, fail_vec);
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_nand_pass();
    test_and_dut();
    test_stuck0();
    test_start_ignored_abort();
    test_async_reset();
    test_restart_from_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- Controller that sequences a 2-input logic gate under test (NAND, AND, OR, etc.) through all four input vectors: 00, 01, 10, 11.
- Holds each vector for a programmable settle time, then samples the gate output and compares it against a parameterised truth table.
- Accumulates mismatch count and a per-vector fail mask, and reports done/pass.
- Sits beside any gate datapath module as an on-chip self-test driver, replacing hand-written delay stimulus.

Parameters:
- HOLD_CYCLES, 10, cycles spent in SETTLE per vector; must be >= 1.
- TRUTH, 4'b0111, expected y indexed by vector {a,b}: bit0 is y for 00, bit3 is y for 11. Default is NAND.
- STOP_ON_FAIL, 0, if 1 the sequence ends at the first mismatch.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sequence; sampled only in IDLE or DONE.
- abort  input  1  synchronous abort; returns to IDLE.
- y_dut  input  1  output of gate under test.
- a  output  1  gate input A, registered.
- b  output  1  gate input B, registered.
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  high in DONE.
- pass  output  1  high in DONE when err_cnt==0.
- err_cnt  output  3  mismatch count, 0..4.
- fail_vec  output  4  bit i set if vector i mismatched.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, vec=0, timer=0. Outputs a=b=busy=done=pass=0, err_cnt=0, fail_vec=0.
- States: IDLE, SETTLE, CHECK, DONE. {a,b} always equals the registered vec[1:0].
- IDLE, start=1 at an edge: next state SETTLE, vec=0, timer=HOLD_CYCLES-1, err_cnt=0, fail_vec=0.
- SETTLE: timer decrements each edge. When timer==0, next state is CHECK. Total SETTLE duration is HOLD_CYCLES cycles.
- CHECK, one cycle. At the edge, sample y_dut and compare with TRUTH[vec]:
  - Mismatch: err_cnt+=1 and fail_vec[vec]=1.
  - If vec==3, or a mismatch occurred with STOP_ON_FAIL=1: next state DONE, and vec is not incremented.
  - Otherwise: vec+=1, timer reloaded to HOLD_CYCLES-1, next state SETTLE.
- Each vector is held HOLD_CYCLES+1 cycles. A full run takes 4*(HOLD_CYCLES+1) cycles from the start edge to done rising.
- DONE:
  - done=1, pass=(err_cnt==0).
  - a and b hold the last vector; err_cnt and fail_vec hold.
  - start=1 restarts exactly as from IDLE, so done drops on the same edge.
- start while busy is ignored.
- abort=1 in any state except IDLE:
  - Next edge: state=IDLE, vec=0, busy=done=pass=0.
  - err_cnt and fail_vec keep their values.
  - abort has priority over start and over CHECK completion on the same edge.
- err_cnt saturates naturally at 4 (3 bits); no wrap is possible.
- y_dut is sampled only in CHECK, and only its registered-edge value matters. The gate under test is combinational; no synchroniser.

Decomposition:
- Package gate_seq_pkg:
  - State encoding enum (IDLE=0, SETTLE=1, CHECK=2, DONE=3).
  - Truth-table constants TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_NOR=4'b0001, TT_XOR=4'b0110, TT_XNOR=4'b1001.
  - Helper for timer width: clog2(HOLD_CYCLES).
- One sub-module: gate_seq_timer, a loadable down-counter with load, en and zero flag, parameterised by width.

Test Plan:
1. NAND DUT, TRUTH=TT_NAND, HOLD=10, pulse start:
   - {a,b} steps 00, 01, 10, 11, each held 11 cycles.
   - done rises 44 cycles after the start edge with pass=1, err_cnt=0, fail_vec=0000.
2. AND DUT with TRUTH=TT_NAND: done at 44 cycles with err_cnt=4, fail_vec=1111, pass=0.
3. y_dut stuck-at-0, TRUTH=TT_NAND:
   - STOP_ON_FAIL=0: done at 44 cycles, err_cnt=3, fail_vec=0111.
   - STOP_ON_FAIL=1: done at 11 cycles, err_cnt=1, fail_vec=0001, {a,b}=00.
4. start pulsed during SETTLE of vector 1: ignored, sequence unchanged. Then abort during CHECK of vector 2:
   - Next edge: IDLE, a=b=0, busy=0.
   - err_cnt and fail_vec retained.
   - A new start clears them and completes normally.
5. rst_n driven low mid-SETTLE between clock edges: a, b, busy, err_cnt and fail_vec read 0 immediately. After release, the block stays IDLE until start.
6. From DONE with pass=0, pulse start with a correct DUT: done=0 on the same edge, err_cnt cleared, second run ends pass=1 at 44 cycles.
